// File: rtl/sr_cmd_gen.sv
// Command front end for the SR flip-flop: synchronizes and debounces the raw set/clear
// buttons, turns debounced rising edges into arbitrated one-cycle s/r pulses, tracks Q.
module sr_cmd_gen #(
   parameter int DEB_CYCLES = 4,
   parameter bit PRIORITY   = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic set_in,
   input  logic clr_in,
   output logic s,
   output logic r,
   output logic conflict,
   output logic state_q
);

   localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

   // Channel 0 is set, channel 1 is clear.
   logic [1:0] raw;
   logic [1:0] sync1;
   logic [1:0] sync2;
   logic [1:0] deb;
   logic [1:0] deb_d;
   logic [1:0] req;
   logic [7:0] cnt [2];
   logic       set_win;
   logic       clr_win;

   assign raw = {clr_in, set_in};

   // Mismatch run length decides when the debounced level follows the synced input.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1  <= '0;
         sync2  <= '0;
         deb    <= '0;
         deb_d  <= '0;
         req    <= '0;
         cnt[0] <= '0;
         cnt[1] <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         for (int ch = 0; ch < 2; ch++) begin
            if (sync2[ch] != deb[ch]) begin
               if (cnt[ch] == DEB_LAST) begin
                  deb[ch] <= sync2[ch];
                  cnt[ch] <= '0;
               end else begin
                  cnt[ch] <= cnt[ch] + 8'd1;
               end
            end else begin
               cnt[ch] <= '0;
            end
         end
         deb_d <= deb;
         req   <= deb & ~deb_d;
      end
   end

   // A losing simultaneous request is simply dropped.
   assign set_win = req[0] & (~req[1] | PRIORITY);
   assign clr_win = req[1] & (~req[0] | ~PRIORITY);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s        <= 1'b0;
         r        <= 1'b0;
         conflict <= 1'b0;
         state_q  <= 1'b0;
      end else begin
         s        <= set_win;
         r        <= clr_win;
         conflict <= req[0] & req[1];
         if (set_win) begin
            state_q <= 1'b1;
         end else if (clr_win) begin
            state_q <= 1'b0;
         end
      end
   end

endmodule

// File: doc/sr_cmd_gen.md
SR_CMD_GEN -- requirements
Module: sr_cmd_gen

Interface
REQ-001 The block SHALL sit directly upstream of the team's SR flip-flop, driving its s/r inputs from two raw command lines.
REQ-002 The block SHALL have parameter DEB_CYCLES, default 4, meaning consecutive mismatching samples required to accept a new debounced level (legal 1..255).
REQ-003 The block SHALL have parameter PRIORITY, default 0, meaning the winner on simultaneous requests: 0 = clear wins, 1 = set wins.
REQ-004 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst  input  1  asynchronous, active-low reset (rst=0 resets).
REQ-006 The block SHALL have port set_in  input  1  raw, asynchronous set command (button level).
REQ-007 The block SHALL have port clr_in  input  1  raw, asynchronous clear command (button level).
REQ-008 The block SHALL have port s  output  1  registered one-cycle set pulse to the SR flip-flop.
REQ-009 The block SHALL have port r  output  1  registered one-cycle reset pulse to the SR flip-flop.
REQ-010 The block SHALL have port conflict  output  1  registered one-cycle flag: a simultaneous request was arbitrated.
REQ-011 The block SHALL have port state_q  output  1  registered copy of the expected SR flip-flop Q.

Function
REQ-012 Each raw input SHALL pass through a 2-flop synchronizer; the value is usable after the 2nd edge following its change.
REQ-013 Each channel SHALL keep an 8-bit counter and a debounced level; counter increments on every edge where synced != debounced, and clears on any edge where they are equal.
REQ-014 On the edge where a mismatch is seen for the DEB_CYCLES-th consecutive time, the debounced level SHALL take the synced value and the counter SHALL clear.
REQ-015 A request SHALL be raised only on a 0->1 transition of a debounced level; 1->0 transitions SHALL produce no output.
REQ-016 Latency: input rising before edge 0 and held stable SHALL give s (or r) high exactly between edges 3+DEB_CYCLES and 4+DEB_CYCLES.
REQ-017 s and r SHALL each be high for exactly one cycle per accepted request, and SHALL never be high in the same cycle.
REQ-018 Both requests in the same cycle: only the PRIORITY winner SHALL pulse; the loser SHALL be dropped (not queued); conflict SHALL pulse in the same cycle as the winner.
REQ-019 Pulses in consecutive cycles (e.g. s then r) SHALL be allowed; no minimum spacing is imposed.
REQ-020 state_q SHALL become 1 on the edge s is asserted and 0 on the edge r is asserted, otherwise hold.
REQ-021 Raw glitches shorter than DEB_CYCLES synced cycles SHALL produce no pulse and no debounced change.
REQ-022 Counter SHALL never wrap; it is bounded by DEB_CYCLES.

Reset
REQ-023 rst=0 SHALL asynchronously clear synchronizers, counters, debounced levels, s, r, conflict and state_q to 0.
REQ-024 Reset mid-debounce SHALL discard the partial count; a pulse in flight SHALL be cut immediately.
REQ-025 An input held high through reset release SHALL be treated as a new rising edge and pulse after the REQ-016 latency counted from the first edge with rst=1.

Verification (DEB_CYCLES=4, PRIORITY=0 unless stated)
REQ-026 rst=0 for 5 cycles with set_in=clr_in=1 -> s=r=conflict=state_q=0 throughout.
REQ-027 set_in 0->1 before edge 0, held 20 cycles -> s=1 only between edges 7 and 8, state_q=1 from edge 7, r=0.
REQ-028 clr_in high for 3 synced cycles then low -> r, s, conflict stay 0, state_q unchanged.
REQ-029 set_in and clr_in rise together -> r=1 and conflict=1 between edges 7 and 8, s=0, state_q=0; repeat with PRIORITY=1 -> s=1, conflict=1, state_q=1.
REQ-030 set_in held, rst pulsed low at edge 5 for 2 cycles -> s stays 0 before release, then s pulses once 7 edges after release.
REQ-031 set_in released after accepted, then clr_in pressed -> no pulse on set release; r pulses once, state_q returns 0.
